phase_sequencer: RTL and testbench

//  Sequences the multi-cycle core pipeline: one instruction at a time through FETCH, DECODE,

---
 rtl/phase_sequencer_pkg.sv | 30 +++
 rtl/phase_counter.sv | 21 ++
 rtl/phase_sequencer.sv | 111 +++++++++++
 tb/tb_phase_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared state encoding, parameter defaults and stage-order helper for phase_sequencer.
package phase_sequencer_pkg;

    typedef enum logic [2:0] {
        PHASE_IDLE   = 3'd0,
        PHASE_FETCH  = 3'd1,
        PHASE_DECODE = 3'd2,
        PHASE_EXEC   = 3'd3,
        PHASE_MEM    = 3'd4,
        PHASE_WB     = 3'd5
    } phase_state_t;

    localparam int          CNT_W_DEFAULT     = 32;
    localparam int unsigned STALL_MAX_DEFAULT = 255;

    // Stage that follows s in the pipeline order; WB/IDLE exits are handled by the FSM.
    function automatic phase_state_t phase_advance(input phase_state_t s);
        phase_state_t n;
        n = s;
        unique case (s)
            PHASE_FETCH:  n = PHASE_DECODE;
            PHASE_DECODE: n = PHASE_EXEC;
            PHASE_EXEC:   n = PHASE_MEM;
            PHASE_MEM:    n = PHASE_WB;
            default:      n = s;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Free-running wrapping event counter used for cycle_cnt and instret_cnt.
module phase_counter
    import phase_sequencer_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle pipeline sequencer: FETCH..WB phase enables, stall handling, counters, watchdog.
// Optional single-step launch input enabled by defining PHASE_SEQ_STEP_EN.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int          CNT_W     = CNT_W_DEFAULT,
    parameter int unsigned STALL_MAX = STALL_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
`ifdef PHASE_SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic             stall_fetch,
    input  logic             stall_decode,
    input  logic             stall_execute,
    input  logic             stall_memoryaccess,
    output logic             phase_fetch,
    output logic             phase_decode,
    output logic             phase_execute,
    output logic             phase_memoryaccess,
    output logic             phase_writeback,
    output logic             busy,
    output logic             inst_retired,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic             stall_err
);

    phase_state_t state;
    logic         cur_stall;
    logic         launch;
    logic [31:0]  stall_cnt;

    always_comb begin
        cur_stall = 1'b0;
        unique case (state)
            PHASE_FETCH:  cur_stall = stall_fetch;
            PHASE_DECODE: cur_stall = stall_decode;
            PHASE_EXEC:   cur_stall = stall_execute;
            PHASE_MEM:    cur_stall = stall_memoryaccess;
            default:      cur_stall = 1'b0;
        endcase
    end

`ifdef PHASE_SEQ_STEP_EN
    logic step_armed;

    // One launch per step assertion; step must drop for a cycle before it can launch again.
    assign launch = run | (step & step_armed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_armed <= 1'b1;
        end else if (state == PHASE_IDLE && !run && step && step_armed) begin
            step_armed <= 1'b0;
        end else if (!step) begin
            step_armed <= 1'b1;
        end
    end
`else
    assign launch = run;
`endif

    // Stall count clears whenever the current state is unstalled: in FETCH..MEM that is exactly
    // a state change, WB always leaves, and IDLE never accumulates a count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PHASE_IDLE;
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            unique case (state)
                PHASE_IDLE: if (launch) state <= PHASE_FETCH;
                PHASE_WB:   state <= run ? PHASE_FETCH : PHASE_IDLE;
                default:    if (!cur_stall) state <= phase_advance(state);
            endcase

            if (cur_stall) begin
                if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 32'd1;
                if (STALL_MAX != 0 && stall_cnt == STALL_MAX - 32'd1) stall_err <= 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    assign phase_fetch        = (state == PHASE_FETCH)  & ~stall_fetch;
    assign phase_decode       = (state == PHASE_DECODE) & ~stall_decode;
    assign phase_execute      = (state == PHASE_EXEC)   & ~stall_execute;
    assign phase_memoryaccess = (state == PHASE_MEM)    & ~stall_memoryaccess;
    assign phase_writeback    = (state == PHASE_WB);
    assign inst_retired       = (state == PHASE_WB);
    assign busy               = (state != PHASE_IDLE);

    phase_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (busy),
        .q     (cycle_cnt)
    );

    phase_counter #(.WIDTH(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inst_retired),
        .q     (instret_cnt)
    );

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: stage-level model plus directed literal checks.
module tb_phase_sequencer;

    localparam int          CNT_W     = 8;
    localparam int unsigned STALL_MAX = 4;
    localparam int unsigned CNT_MOD   = 1 << CNT_W;
    localparam int          VW        = 8 + 2 * CNT_W;

    logic clk = 1'b0;
    logic rst_n, run, stall_fetch, stall_decode, stall_execute, stall_memoryaccess;
`ifdef PHASE_SEQ_STEP_EN
    logic step;
`endif
    logic phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback;
    logic busy, inst_retired, stall_err;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
    logic [4:0] phases;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    assign phases = {phase_writeback, phase_memoryaccess, phase_execute, phase_decode, phase_fetch};

    phase_sequencer #(.CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .run                (run),
`ifdef PHASE_SEQ_STEP_EN
        .step               (step),
`endif
        .stall_fetch        (stall_fetch),
        .stall_decode       (stall_decode),
        .stall_execute      (stall_execute),
        .stall_memoryaccess (stall_memoryaccess),
        .phase_fetch        (phase_fetch),
        .phase_decode       (phase_decode),
        .phase_execute      (phase_execute),
        .phase_memoryaccess (phase_memoryaccess),
        .phase_writeback    (phase_writeback),
        .busy               (busy),
        .inst_retired       (inst_retired),
        .cycle_cnt          (cycle_cnt),
        .instret_cnt        (instret_cnt),
        .stall_err          (stall_err)
    );

    // Model: stage index 0 = idle, 1..5 = fetch, decode, exec, mem, writeback.
    int          m_stage = 0;
    int unsigned m_cyc   = 0;
    int unsigned m_ret   = 0;
    int unsigned m_run_len = 0;
    bit          m_err   = 1'b0;
    bit          m_armed = 1'b1;

    function automatic bit stage_stalled(input int s);
        bit r;
        r = 1'b0;
        if (s == 1) r = stall_fetch;
        if (s == 2) r = stall_decode;
        if (s == 3) r = stall_execute;
        if (s == 4) r = stall_memoryaccess;
        return r;
    endfunction

    function automatic bit step_launch();
`ifdef PHASE_SEQ_STEP_EN
        return step && m_armed;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int stage_after(input int s);
        int n;
        if (s == 0)                 n = (run || step_launch()) ? 1 : 0;
        else if (s == 5)            n = run ? 1 : 0;
        else if (stage_stalled(s))  n = s;
        else                        n = s + 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stage   <= 0;
            m_cyc     <= 0;
            m_ret     <= 0;
            m_run_len <= 0;
            m_err     <= 1'b0;
            m_armed   <= 1'b1;
        end else begin
            m_stage <= stage_after(m_stage);
            if (m_stage != 0) m_cyc <= (m_cyc + 1) % CNT_MOD;
            if (m_stage == 5) m_ret <= (m_ret + 1) % CNT_MOD;
            if (stage_stalled(m_stage)) begin
                if (m_run_len < STALL_MAX) m_run_len <= m_run_len + 1;
                if (STALL_MAX != 0 && m_run_len + 1 >= STALL_MAX) m_err <= 1'b1;
            end else begin
                m_run_len <= 0;
            end
`ifdef PHASE_SEQ_STEP_EN
            if (m_stage == 0 && !run && step && m_armed) m_armed <= 1'b0;
            else if (!step)                               m_armed <= 1'b1;
`endif
        end
    end

    logic [VW-1:0] exp_v, act_v;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (!rst_n) begin
                exp_v = '0;
            end else begin
                exp_v = {m_stage == 5,
                         m_stage == 4 && !stall_memoryaccess,
                         m_stage == 3 && !stall_execute,
                         m_stage == 2 && !stall_decode,
                         m_stage == 1 && !stall_fetch,
                         m_stage != 0, m_stage == 5, m_err,
                         m_cyc[CNT_W-1:0], m_ret[CNT_W-1:0]};
            end
            act_v = {phases, busy, inst_retired, stall_err, cycle_cnt, instret_cnt};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_compare @%0t: got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    logic [4:0]       ep [7];
    logic             sd [7];
    logic [4:0]       e;
    logic [CNT_W-1:0] base;

    initial begin
        rst_n = 1'b0; run = 1'b0;
        stall_fetch = 1'b0; stall_decode = 1'b0; stall_execute = 1'b0; stall_memoryaccess = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
        step = 1'b0;
`endif
        go(); go();
        cmp_en = 1'b1;

        // cycle 0: leave reset with run already high
        go(); rst_n = 1'b1; run = 1'b1;
        mid();
        chk("reset_busy", busy, 0);
        chk("reset_phases", phases, 0);
        chk("reset_cycle_cnt", cycle_cnt, 0);
        chk("reset_instret_cnt", instret_cnt, 0);
        chk("reset_stall_err", stall_err, 0);

        for (int c = 1; c <= 20; c++) begin
            go(); mid();
            e = 5'b00001 << ((c - 1) % 5);
            chk("t1_phase", phases, e);
        end
        go(); mid();                                  // cycle 21, FETCH
        chk("t1_cycle_cnt", cycle_cnt, 20);
        chk("t1_instret_cnt", instret_cnt, 4);
        chk("t1_refetch", phases, 5'b00001);

        // decode stalled for its first 3 cycles: cycles 22..28
        sd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ep = '{5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        for (int i = 0; i < 7; i++) begin
            go(); stall_decode = sd[i];
            mid();
            chk("t2_phase", phases, ep[i]);
        end

        // run dropped in EXEC: cycles 29..34
        go(); mid(); chk("t3_fetch", phases, 5'b00001);
        go(); mid(); chk("t3_decode", phases, 5'b00010);
        go(); run = 1'b0; mid(); chk("t3_exec", phases, 5'b00100);
        go(); mid(); chk("t3_mem", phases, 5'b01000);
        go(); mid(); chk("t3_wb", phases, 5'b10000); chk("t3_retired", inst_retired, 1);
        go(); mid();
        chk("t3_idle_busy", busy, 0);
        chk("t3_idle_phases", phases, 0);
        chk("t3_cycle_cnt", cycle_cnt, 33);
        chk("t3_instret_cnt", instret_cnt, 6);
        repeat (5) go();
        mid();
        chk("t3_cycle_frozen", cycle_cnt, 33);
        chk("t3_instret_frozen", instret_cnt, 6);

        // watchdog: 3-cycle MEM stall (44..46) then 4-cycle MEM stall (52..55)
        go(); run = 1'b1; mid(); chk("t4_idle", busy, 0);
        go(); go(); go();
        for (int i = 0; i < 3; i++) begin
            go(); stall_memoryaccess = 1'b1;
            mid();
            chk("t4_short_phases", phases, 0);
            chk("t4_short_err", stall_err, 0);
        end
        go(); stall_memoryaccess = 1'b0; mid();
        chk("t4_short_mem", phases, 5'b01000);
        chk("t4_short_err_after", stall_err, 0);
        go(); mid(); chk("t4_short_err_wb", stall_err, 0);
        go(); go(); go();
        for (int i = 0; i < 4; i++) begin
            go(); stall_memoryaccess = 1'b1;
            mid();
            chk("t4_long_phases", phases, 0);
        end
        go(); stall_memoryaccess = 1'b0; mid();
        chk("t4_long_err", stall_err, 1);
        chk("t4_long_mem", phases, 5'b01000);
        go(); run = 1'b0; mid(); chk("t4_err_sticky_wb", stall_err, 1);
        go(); mid();
        chk("t4_err_sticky_idle", stall_err, 1);
        chk("t4_cycle_cnt", cycle_cnt, 50);
        chk("t4_instret_cnt", instret_cnt, 8);

        // reset pulse during MEM
        go(); run = 1'b1;
        go(); go(); go(); go();
        mid(); chk("t5_mem", phases, 5'b01000);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_phases_async", phases, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_cycle_async", cycle_cnt, 0);
        chk("t5_instret_async", instret_cnt, 0);
        chk("t5_err_async", stall_err, 0);
        go(); rst_n = 1'b1; mid();                    // cycle 64, IDLE
        chk("t5_idle", busy, 0);
        go(); mid();                                  // cycle 65
        chk("t5_restart_fetch", phases, 5'b00001);

        // counter wrap: busy continuously from cycle 65
        repeat (255) go();
        mid();
        chk("wrap_cycle_255", cycle_cnt, 255);
        go(); run = 1'b0; mid();                      // cycle 321, DECODE
        chk("wrap_cycle_0", cycle_cnt, 0);
        chk("wrap_instret", instret_cnt, 51);
        chk("wrap_decode", phases, 5'b00010);
        repeat (4) go();
        mid();
        chk("wrap_idle", busy, 0);

`ifdef PHASE_SEQ_STEP_EN
        base = instret_cnt;
        for (int i = 0; i < 12; i++) begin
            go(); step = 1'b1;
        end
        mid();
        chk("step_held_busy", busy, 0);
        chk("step_held_one", instret_cnt - base, 1);
        go(); step = 1'b0;
        go(); step = 1'b1;
        repeat (7) go();
        step = 1'b0;
        mid();
        chk("step_rearm_two", instret_cnt - base, 2);
        chk("step_rearm_idle", busy, 0);
`endif

        go(); mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
